inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Front-end sequencer for the out-of-order core: fetches instructions from the instruction cache one request at a time and buffers them with their PCs in a small FIFO. It feeds the decoder one instruction per cycle through `inst_req`, holding off while the issue side reports a stall. It redirects fetch on JAL and flushes and redirects on ROB mispredict.

## Interface
- `QUEUE_DEPTH_LOG`, default 2: the FIFO holds 2^QUEUE_DEPTH_LOG entries (default 4).
- `RESET_PC`, default 32'h0: first fetch address after reset.

Ports:
- `clk_in`  in  1: clock.
- `rst_in`  in  1: synchronous, active-high reset.
- `rdy_in`  in  1: global pause. When low, the block freezes.
- `icache_req_out`  out  1: fetch request valid.
- `icache_addr_out`  out  32: fetch address. Stable while the request is pending.
- `icache_ready_in`  in  1: fetched word valid. It answers the pending request.
- `icache_inst_in`  in  32: fetched instruction word.
- `dec_req_out`  out  1: one-cycle pulse that drives the decoder's `inst_req`.
- `dec_inst_out`  out  32: instruction word to the decoder.
- `dec_pc_out`  out  32: PC of `dec_inst_out`.
- `issue_stall_in`  in  1: ROB, RS or LSB full. Do not hand out instructions.
- `flush_in`  in  1: mispredict or redirect from the ROB.
- `flush_pc_in`  in  32: correct PC. Valid with `flush_in`.

## Operation
- Internal state: fetch PC `pc`, FIFO of {inst, pc}, `count` (0..DEPTH), FSM `state`.
- FSM states:
  - S_REQ: no request outstanding.
    - If `count < DEPTH`, set `icache_req_out<=1` and `icache_addr_out<=pc`, then go to S_WAIT.
    - Otherwise stay in S_REQ with the request low.
  - S_WAIT: request outstanding. Hold the request and address until `icache_ready_in`. On the response:
    - Enqueue {`icache_inst_in`, `pc`}.
    - Drop `icache_req_out`.
    - Update `pc` by the next-PC rule.
    - Go to S_REQ.
  - S_DROP: a stale request is outstanding after a flush. On `icache_ready_in`, discard the word, drop the request and go to S_REQ. `pc` already holds the flush PC.
- Next-PC rule:
  - If opcode `[6:0]` is 7'b1101111 (JAL), `pc <= pc + sext({i[31],i[19:12],i[20],i[30:21],1'b0})`.
  - Otherwise `pc <= pc + 4`.
  - Arithmetic is 32-bit modulo, and wrap-around is allowed.
  - Branches and JALR are predicted fall-through. The ROB corrects them through a flush.
- FIFO space is guaranteed: a request is only issued when `count < DEPTH`, and with a single request outstanding nothing else can enqueue in between.
- Dequeue: if `count > 0` and `!issue_stall_in`, pop the head into `dec_inst_out`/`dec_pc_out` and set `dec_req_out<=1`. Otherwise `dec_req_out<=0`, and the data outputs hold.
- Enqueue and dequeue can happen in the same cycle. `count` then stays unchanged, and the order is preserved. The head pointer wraps modulo DEPTH.
- Flush (`flush_in` high, `rdy_in` high) has priority over everything else in that cycle:
  - Empty the FIFO: count 0, pointers reset.
  - Set `dec_req_out<=0` and `pc<=flush_pc_in`.
  - Drop any enqueue or dequeue for that cycle.
  - FSM: from S_WAIT without `icache_ready_in`, go to S_DROP and keep the request asserted. From S_WAIT or S_DROP with `icache_ready_in` in the same cycle, discard the word, drop the request and go to S_REQ. From S_REQ, stay in S_REQ. From S_DROP without `icache_ready_in`, stay in S_DROP.
- `rdy_in` low: no state or output changes, and `icache_ready_in` and `flush_in` are ignored. The memory side is paused by the same signal.
- `rst_in` high: takes effect at any point, including mid-request. An outstanding icache response that arrives after reset is ignored while the block is in S_REQ with the request low.

## Timing
- Reset values:
  - `icache_req_out=0`, `icache_addr_out=RESET_PC`.
  - `dec_req_out=0`, `dec_inst_out=0`, `dec_pc_out=0`.
  - `pc=RESET_PC`, `count=0`, `state=S_REQ`.
- Edge numbering counts rising edges after `rst_in` falls.
- First request: `icache_req_out` is high after the first edge with `rst_in` low and `rdy_in` high.
- Request spacing: at least one idle cycle of `icache_req_out` low between consecutive requests, so the fetch rate is at most one instruction per two cycles plus icache latency.
- Queue latency: a word enqueued at edge N can appear on `dec_req_out` at edge N+1 at the earliest. There is no bypass.
- `dec_req_out` is high for exactly one cycle per instruction, and never twice for the same FIFO entry.
- After a flush at edge F, the earliest request to `flush_pc_in` is high after edge F+1, or after the stale response is dropped.

## Test plan
- Reset, then the icache answers 1 cycle after each request with ADDI words: `icache_addr_out` sequence is 0x0, 0x4, 0x8. `dec_req_out` pulses with pc 0x0 then 0x4, in order, never duplicated.
- JAL with imm +16 at 0x8: the next request address is 0x18. JAL with imm −8 at 0x18: the next request is 0x10.
- `issue_stall_in` held high, default depth: 4 words are enqueued and `icache_req_out` then stays low. On release, 4 consecutive `dec_req_out` pulses with pc 0x0, 0x4, 0x8, 0xC.
- `flush_in` with `flush_pc_in=0x100` while a request to 0x20 is outstanding, response 2 cycles later: that word is never on `dec_inst_out`, and the next `icache_addr_out` is 0x100.
- `flush_in` in the same cycle as `icache_ready_in`: the word is discarded, the FIFO is empty, and a request to 0x100 is issued on the following cycle.
- `rdy_in` low for 3 cycles mid-stream with `icache_ready_in` toggling: all outputs hold. After resume, the PC sequence on `dec_pc_out` is contiguous, with no loss or duplication.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding icache request at a time,
// a small {inst, pc} FIFO toward the decoder, JAL redirect and ROB flush.
module inst_fetch_ctrl #(
    parameter int          QUEUE_DEPTH_LOG = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_out,
    output logic [31:0] icache_addr_out,
    input  logic        icache_ready_in,
    input  logic [31:0] icache_inst_in,
    output logic        dec_req_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out,
    input  logic        issue_stall_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in
);
    localparam int                   DEPTH   = 1 << QUEUE_DEPTH_LOG;
    localparam logic [QUEUE_DEPTH_LOG:0] DEPTH_C = (QUEUE_DEPTH_LOG+1)'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t                     r_state;
    logic [31:0]                r_pc;
    logic [QUEUE_DEPTH_LOG:0]   r_count;
    logic [QUEUE_DEPTH_LOG-1:0] r_head;
    logic [QUEUE_DEPTH_LOG-1:0] r_tail;
    logic [31:0]                r_inst_mem [DEPTH];
    logic [31:0]                r_pc_mem   [DEPTH];

    logic        w_enq;
    logic        w_deq;
    logic        w_is_jal;
    logic [31:0] w_jal_imm;
    logic [31:0] w_next_pc;

    // A response only lands in the FIFO from S_WAIT, and never in a flush cycle.
    assign w_enq     = !rst_in && rdy_in && !flush_in && (r_state == S_WAIT) && icache_ready_in;
    assign w_deq     = (r_count != '0) && !issue_stall_in;
    assign w_is_jal  = (icache_inst_in[6:0] == 7'b1101111);
    assign w_jal_imm = {{11{icache_inst_in[31]}}, icache_inst_in[31], icache_inst_in[19:12],
                        icache_inst_in[20], icache_inst_in[30:21], 1'b0};
    // Only JAL is followed; branches and JALR fall through until the ROB flushes.
    assign w_next_pc = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);

    // FIFO storage: written at the tail with the word and the PC it was fetched from.
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_inst_mem[r_tail] <= icache_inst_in;
            r_pc_mem[r_tail]   <= r_pc;
        end
    end

    // Control: fetch FSM, FIFO pointers/count, decoder handoff, flush handling.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state         <= S_REQ;
            r_pc            <= RESET_PC;
            r_count         <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            icache_req_out  <= 1'b0;
            icache_addr_out <= RESET_PC;
            dec_req_out     <= 1'b0;
            dec_inst_out    <= 32'h0;
            dec_pc_out      <= 32'h0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_count     <= '0;
                r_head      <= '0;
                r_tail      <= '0;
                dec_req_out <= 1'b0;
                r_pc        <= flush_pc_in;
                // An in-flight request must still be answered; its word is thrown away.
                case (r_state)
                    S_WAIT, S_DROP: begin
                        if (icache_ready_in) begin
                            icache_req_out <= 1'b0;
                            r_state        <= S_REQ;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                    default: r_state <= S_REQ;
                endcase
            end else begin
                if (w_enq)
                    r_tail <= r_tail + 1'b1;
                if (w_deq) begin
                    dec_inst_out <= r_inst_mem[r_head];
                    dec_pc_out   <= r_pc_mem[r_head];
                    dec_req_out  <= 1'b1;
                    r_head       <= r_head + 1'b1;
                end else begin
                    dec_req_out <= 1'b0;
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                case (r_state)
                    S_REQ: begin
                        if (r_count < DEPTH_C) begin
                            icache_req_out  <= 1'b1;
                            icache_addr_out <= r_pc;
                            r_state         <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (icache_ready_in) begin
                            icache_req_out <= 1'b0;
                            r_pc           <= w_next_pc;
                            r_state        <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (icache_ready_in) begin
                            icache_req_out <= 1'b0;
                            r_state        <= S_REQ;
                        end
                    end
                    default: r_state <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: auto-responding icache model plus
// manual response control for flush and pause scenarios.
module tb_inst_fetch_ctrl;
    typedef logic [31:0] wq_t[$];

    logic        clk_in, rst_in, rdy_in;
    logic        icache_req_out, icache_ready_in;
    logic [31:0] icache_addr_out, icache_inst_in;
    logic        dec_req_out;
    logic [31:0] dec_inst_out, dec_pc_out;
    logic        issue_stall_in, flush_in;
    logic [31:0] flush_pc_in;

    int checks = 0;
    int errors = 0;

    // icache model controls
    logic        auto_md, jal_en, pause_tog, man_ready;
    logic [31:0] man_inst;
    int          rcnt;
    int          cyc;
    logic        last_rdy, prev_req;
    wq_t         req_q, pc_q, inst_q, cyc_q;

    localparam logic [31:0] JAL_P16 = 32'h0100006F;
    localparam logic [31:0] JAL_M8  = 32'hFF9FF06F;
    localparam logic [31:0] W_STALE = 32'hABC00093;
    localparam logic [31:0] W_FLSH  = 32'h55500093;
    localparam logic [31:0] W_NEW   = 32'h10000093;

    inst_fetch_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_req_out(icache_req_out), .icache_addr_out(icache_addr_out),
        .icache_ready_in(icache_ready_in), .icache_inst_in(icache_inst_in),
        .dec_req_out(dec_req_out), .dec_inst_out(dec_inst_out), .dec_pc_out(dec_pc_out),
        .issue_stall_in(issue_stall_in), .flush_in(flush_in), .flush_pc_in(flush_pc_in)
    );

    initial begin
        clk_in = 0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_en && a == 32'h8)  return JAL_P16;
        if (jal_en && a == 32'h18) return JAL_M8;
        return {a[19:0], 12'h093};
    endfunction

    assign icache_ready_in = pause_tog ? man_ready :
                             auto_md   ? (icache_req_out && rcnt >= 1) : man_ready;
    assign icache_inst_in  = auto_md ? mem_word(icache_addr_out) : man_inst;

    // auto responder: answer one cycle after the request appears
    always @(posedge clk_in) begin
        cyc      <= cyc + 1;
        last_rdy <= rdy_in;
        if (rst_in)      rcnt <= 0;
        else if (rdy_in) rcnt <= (icache_req_out && !icache_ready_in) ? rcnt + 1 : 0;
    end

    // monitor: record new requests and decoder handoffs on active edges only
    always @(negedge clk_in) begin
        if (!rst_in && last_rdy) begin
            if (icache_req_out && !prev_req) req_q.push_back(icache_addr_out);
            if (dec_req_out) begin
                pc_q.push_back(dec_pc_out);
                inst_q.push_back(dec_inst_out);
                cyc_q.push_back(32'(cyc));
            end
        end
        prev_req <= icache_req_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input wq_t q, input int i);
        return (i < q.size()) ? q[i] : 32'hDEADBEEF;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    task automatic clr_q();
        req_q.delete(); pc_q.delete(); inst_q.delete(); cyc_q.delete();
    endtask

    task automatic do_reset();
        rst_in = 1; flush_in = 0; man_ready = 0; pause_tog = 0;
        step(3);
        rst_in = 0;
        clr_q();
    endtask

    task automatic wait_req();
        for (int k = 0; k < 50 && !icache_req_out; k++) step(1);
        chk("req_wait", 32'(icache_req_out), 32'd1);
    endtask

    task automatic serve(input logic [31:0] w);
        wait_req();
        man_ready = 1; man_inst = w;
        step(1);
        man_ready = 0;
    endtask

    initial begin
        logic [31:0] s_addr, s_pc, s_inst, s_req;
        int          d0;
        logic [31:0] found;
        rst_in = 1; rdy_in = 1; issue_stall_in = 0; flush_in = 0; flush_pc_in = 0;
        auto_md = 1; jal_en = 0; pause_tog = 0; man_ready = 0; man_inst = 0;
        rcnt = 0; cyc = 0; last_rdy = 1; prev_req = 0;

        // reset values
        step(3);
        chk("rst_req",  32'(icache_req_out), 0);
        chk("rst_addr", icache_addr_out, 32'h0);
        chk("rst_dreq", 32'(dec_req_out), 0);
        chk("rst_inst", dec_inst_out, 32'h0);
        chk("rst_pc",   dec_pc_out, 32'h0);

        // sequential fetch with JAL +16 at 0x8 and JAL -8 at 0x18
        jal_en = 1;
        rst_in = 0; clr_q();
        step(1);
        chk("first_req",  32'(icache_req_out), 1);
        chk("first_addr", icache_addr_out, 32'h0);
        for (int k = 0; k < 100 && req_q.size() < 6; k++) step(1);
        step(2);
        begin
            logic [31:0] ea[6] = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h10, 32'h14};
            for (int i = 0; i < 6; i++) chk($sformatf("seq_addr%0d", i), at(req_q, i), ea[i]);
            for (int i = 0; i < 5; i++) chk($sformatf("seq_pc%0d", i), at(pc_q, i), ea[i]);
        end
        chk("seq_inst0", at(inst_q, 0), 32'h00000093);
        chk("seq_inst2", at(inst_q, 2), JAL_P16);

        // stall: fill the FIFO, then drain in a burst
        jal_en = 0; issue_stall_in = 1;
        do_reset();
        step(30);
        chk("stall_nreq", 32'(req_q.size()), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("stall_addr%0d", i), at(req_q, i), 32'(4*i));
        chk("stall_ndec", 32'(pc_q.size()), 0);
        chk("stall_reqlo", 32'(icache_req_out), 0);
        issue_stall_in = 0;
        for (int k = 0; k < 50 && pc_q.size() < 4; k++) step(1);
        for (int i = 0; i < 4; i++) chk($sformatf("drain_pc%0d", i), at(pc_q, i), 32'(4*i));
        chk("drain_span", at(cyc_q, 3) - at(cyc_q, 0), 32'd3);

        // flush with request to 0x20 outstanding, stale response two cycles later
        auto_md = 0;
        do_reset();
        for (int i = 0; i < 8; i++) serve(32'h00000013);
        wait_req();
        chk("fl_addr20", icache_addr_out, 32'h20);
        flush_in = 1; flush_pc_in = 32'h100;
        step(1);
        flush_in = 0;
        chk("fl_hold_req",  32'(icache_req_out), 1);
        chk("fl_hold_addr", icache_addr_out, 32'h20);
        chk("fl_dreq",      32'(dec_req_out), 0);
        step(1);
        man_ready = 1; man_inst = W_STALE;
        step(1);
        man_ready = 0;
        chk("fl_drop_req", 32'(icache_req_out), 0);
        step(1);
        chk("fl_new_req",  32'(icache_req_out), 1);
        chk("fl_new_addr", icache_addr_out, 32'h100);
        for (int i = 0; i < 8; i++) chk($sformatf("fl_pc%0d", i), at(pc_q, i), 32'(4*i));

        // flush coinciding with a response, FIFO holding two words
        issue_stall_in = 1;
        serve(32'h00000013);
        serve(32'h00000013);
        wait_req();
        chk("fr_addr108", icache_addr_out, 32'h108);
        man_ready = 1; man_inst = W_FLSH; flush_in = 1; flush_pc_in = 32'h100;
        step(1);
        man_ready = 0; flush_in = 0;
        chk("fr_req",  32'(icache_req_out), 0);
        chk("fr_dreq", 32'(dec_req_out), 0);
        d0 = pc_q.size();
        step(1);
        chk("fr_new_req",  32'(icache_req_out), 1);
        chk("fr_new_addr", icache_addr_out, 32'h100);
        issue_stall_in = 0;
        step(4);
        chk("fr_empty", 32'(pc_q.size()), 32'(d0));
        serve(W_NEW);
        step(3);
        chk("fr_ndec", 32'(pc_q.size()), 32'(d0 + 1));
        chk("fr_pc",   at(pc_q, d0), 32'h100);
        chk("fr_inst", at(inst_q, d0), W_NEW);
        found = 0;
        foreach (inst_q[i]) if (inst_q[i] == W_STALE || inst_q[i] == W_FLSH) found = 1;
        chk("no_stale", found, 0);

        // global pause mid-stream with icache_ready_in toggling
        auto_md = 1;
        do_reset();
        step(7);
        s_req  = {30'h0, icache_req_out, dec_req_out};
        s_addr = icache_addr_out; s_pc = dec_pc_out; s_inst = dec_inst_out;
        rdy_in = 0; pause_tog = 1;
        for (int k = 0; k < 3; k++) begin
            man_ready = ~man_ready;
            step(1);
            chk($sformatf("pz_req%0d", k),  {30'h0, icache_req_out, dec_req_out}, s_req);
            chk($sformatf("pz_addr%0d", k), icache_addr_out, s_addr);
            chk($sformatf("pz_pc%0d", k),   dec_pc_out, s_pc);
            chk($sformatf("pz_inst%0d", k), dec_inst_out, s_inst);
        end
        rdy_in = 1; pause_tog = 0; man_ready = 0;
        for (int k = 0; k < 200 && pc_q.size() < 10; k++) step(1);
        for (int i = 0; i < 10; i++) chk($sformatf("pz_seq%0d", i), at(pc_q, i), 32'(4*i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
